// File: rtl/mul_unit.sv
// Iterative RV64 M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW) on the MUL issue port.
// Latency: accept at T, one-cycle writeback pulse at T+1+DATA_WIDTH/STEP (T+17 by default).
// Backpressure: issue_ready low while busy; no writeback stall, result must be taken in DONE.
module mul_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int PRF_WIDTH   = 6,
  parameter int STEP        = 4,
  parameter int OPSEL_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [OPSEL_WIDTH-1:0] op_sel,
  input  logic [DATA_WIDTH-1:0]  src0,
  input  logic [DATA_WIDTH-1:0]  src1,
  input  logic [PRF_WIDTH-1:0]   prd,
  input  logic                   prd_v,
  input  logic                   flush,
  output logic                   busy,
  output logic                   wb_valid,
  output logic [PRF_WIDTH-1:0]   wb_prd,
  output logic                   wb_prd_v,
  output logic [DATA_WIDTH-1:0]  wb_data,
  output logic                   muti_finish
);

  localparam int ITER  = DATA_WIDTH / STEP;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int HALF  = DATA_WIDTH / 2;
  localparam int PW    = 2 * DATA_WIDTH;

  localparam logic [OPSEL_WIDTH-1:0] OP_MULH   = OPSEL_WIDTH'(1);
  localparam logic [OPSEL_WIDTH-1:0] OP_MULHSU = OPSEL_WIDTH'(2);
  localparam logic [OPSEL_WIDTH-1:0] OP_MULHU  = OPSEL_WIDTH'(3);
  localparam logic [OPSEL_WIDTH-1:0] OP_MULW   = OPSEL_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         counter;
  logic [PW-1:0]            acc, mcand, pp_sum, acc_sum, product;
  logic [DATA_WIDTH-1:0]    mplier;
  logic                     neg_q;
  logic [OPSEL_WIDTH-1:0]   op_q;
  logic [PRF_WIDTH-1:0]     prd_q;
  logic                     prd_v_q;
  logic                     accept, last_iter;
  logic [DATA_WIDTH-1:0]    opa, opb, mag_a, mag_b, res_sel;
  logic                     sign_a, sign_b;

  assign accept    = (state == S_IDLE) && issue_valid && !flush;
  assign last_iter = (state == S_BUSY) && (counter == CNT_W'(1));

  // Decode operand signedness per op and reduce both operands to magnitudes
  always_comb begin
    opa    = src0;
    opb    = src1;
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op_sel)
      OP_MULH: begin
        sign_a = src0[DATA_WIDTH-1];
        sign_b = src1[DATA_WIDTH-1];
      end
      OP_MULHSU: sign_a = src0[DATA_WIDTH-1];
      OP_MULW: begin
        opa    = {{HALF{src0[HALF-1]}}, src0[HALF-1:0]};
        opb    = {{HALF{src1[HALF-1]}}, src1[HALF-1:0]};
        sign_a = src0[HALF-1];
        sign_b = src1[HALF-1];
      end
      default: ;
    endcase
    mag_a = sign_a ? -opa : opa;
    mag_b = sign_b ? -opb : opb;
  end

  // Sum STEP shifted partial products for this iteration; fix sign on the final one
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) pp_sum = pp_sum + (mcand << i);
    end
    acc_sum = acc + pp_sum;
    product = neg_q ? -acc_sum : acc_sum;
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: res_sel = product[PW-1:DATA_WIDTH];
      OP_MULW: res_sel = {{HALF{product[HALF-1]}}, product[HALF-1:0]};
      default: res_sel = product[DATA_WIDTH-1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake/writeback strobes; flush always returns to IDLE
  always_comb begin
    state_nxt   = state;
    issue_ready = 1'b0;
    busy        = 1'b1;
    wb_valid    = 1'b0;
    muti_finish = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready = 1'b1;
        busy        = 1'b0;
        if (issue_valid && !flush) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (counter == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        wb_valid    = !flush;
        muti_finish = !flush;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Operand capture, shift-add iteration, and result registers loaded on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter  <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      prd_q    <= '0;
      prd_v_q  <= 1'b0;
      wb_data  <= '0;
      wb_prd   <= '0;
      wb_prd_v <= 1'b0;
    end else if (accept) begin
      counter <= CNT_W'(ITER);
      acc     <= '0;
      mcand   <= {{DATA_WIDTH{1'b0}}, mag_a};
      mplier  <= mag_b;
      neg_q   <= sign_a ^ sign_b;
      op_q    <= op_sel;
      prd_q   <= prd;
      prd_v_q <= prd_v;
    end else if (state == S_BUSY) begin
      counter <= counter - CNT_W'(1);
      acc     <= acc_sum;
      mcand   <= mcand << STEP;
      mplier  <= mplier >> STEP;
      if (last_iter && !flush) begin
        wb_data  <= res_sel;
        wb_prd   <= prd_q;
        wb_prd_v <= prd_v_q;
      end
    end
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative multi-cycle integer multiplier functional unit for RV64 M-extension multiplies; sits directly downstream of the issue stage on the MUL issue port.
- Accepts one issued instruction (operands, op select, destination tag), computes over a fixed number of cycles, presents a one-cycle writeback.
- Drives muti_finish back to the issue stage's arbiter/wake-up logic so the MUL port can be re-granted and dependents of prd can be woken.

Parameters:
- DATA_WIDTH, 64, operand and result width.
- PRF_WIDTH, 6, physical register tag width.
- STEP, 4, multiplier bits retired per BUSY cycle; must divide DATA_WIDTH.
- OPSEL_WIDTH, 3, width of op_sel.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  issue stage presents a MUL instruction.
- issue_ready  out  1  unit can accept this cycle.
- op_sel  in  OPSEL_WIDTH  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 treated as MUL.
- src0  in  DATA_WIDTH  rs1 operand.
- src1  in  DATA_WIDTH  rs2 operand.
- prd  in  PRF_WIDTH  destination physical register.
- prd_v  in  1  instruction writes prd.
- flush  in  1  kill in-flight operation (branch mispredict/exception).
- busy  out  1  operation in flight (BUSY or DONE).
- wb_valid  out  1  result valid, one-cycle pulse.
- wb_prd  out  PRF_WIDTH  destination tag of result.
- wb_prd_v  out  1  result writes PRF.
- wb_data  out  DATA_WIDTH  result.
- muti_finish  out  1  equals wb_valid; tells issue that the multi-cycle op is done.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. Reset wins over all other inputs.
- Reset values:
  - Internal state: state=IDLE, counter=0, accumulator=0.
  - Outputs: issue_ready=1, busy=0, wb_valid=0, muti_finish=0, wb_prd=0, wb_prd_v=0, wb_data=0.
- FSM states:
  - IDLE: issue_ready=1. On issue_valid & ~flush, latch operands, op_sel, prd, prd_v; set counter=DATA_WIDTH/STEP; go to BUSY.
  - BUSY: each cycle add STEP partial products of the magnitude multiplier into a 2*DATA_WIDTH accumulator, then decrement counter. When counter reaches 1, the final iteration completes and the next state is DONE.
  - DONE: wb_valid=muti_finish=1 for exactly this cycle; wb_data, wb_prd and wb_prd_v are stable. Next state is IDLE.
- Handshake: accept only when issue_valid & issue_ready in the same cycle. issue_ready=0 in BUSY and DONE. There is no back-pressure on writeback; the result must be consumed in the DONE cycle.
- Latency: accept at cycle T, wb_valid at T+1+DATA_WIDTH/STEP (T+17 with defaults). Iteration count is fixed: no early-out on zero or small operands.
- Operand signedness (negative means MSB set under signed interpretation):
  - MULH: both operands signed.
  - MULHSU: src0 signed, src1 unsigned.
  - MULHU: both operands unsigned.
  - MUL: low half of the product is sign-agnostic; compute unsigned.
  - MULW: operands are the low 32 bits sign-extended to 64, treated as signed.
- Arithmetic: multiply the magnitudes. The negate flag is the XOR of the operand signs. Apply a 2*DATA_WIDTH two's-complement negation at the transition into DONE when the flag is set.
- Result select:
  - MUL: product[63:0].
  - MULH, MULHSU, MULHU: product[127:64].
  - MULW: sign-extend(product[31:0]) to 64.
- Registered outputs: wb_data, wb_prd and wb_prd_v are registered on entry to DONE and hold their value until the next DONE. wb_valid is a one-cycle pulse.
- Flush:
  - A flush in any cycle forces next state to IDLE.
  - wb_valid and muti_finish are gated combinationally by ~flush, so a flush during DONE suppresses writeback.
  - flush together with issue_valid in IDLE: the instruction is not accepted.
- Reset mid-operation: the operation is abandoned with no wb_valid. The unit is in IDLE with issue_ready=1 in the cycle after rst_n is sampled low.
- busy = (state != IDLE).

Test Plan:
- Reset then MUL with src0=7, src1=6, prd=0x12, prd_v=1 at T -> issue_ready=0 from T+1 through T+17; wb_valid only at T+17; wb_data=42; wb_prd=0x12; wb_prd_v=1; issue_ready=1 at T+18.
- Signed corners:
  - MULH, src0=src1=0x8000_0000_0000_0000 -> wb_data=0x4000_0000_0000_0000.
  - MULHU, src0=src1=0xFFFF_FFFF_FFFF_FFFF -> wb_data=0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU, src0=-1, src1=2 -> wb_data=0xFFFF_FFFF_FFFF_FFFF.
- MULW, src0=0x0000_0001_7FFF_FFFF, src1=2 -> wb_data=0xFFFF_FFFF_FFFF_FFFE. Also MUL, src0=-3, src1=5 -> wb_data=0xFFFF_FFFF_FFFF_FFF1.
- Flush paths:
  - Flush at T+5 of an accepted op -> no wb_valid ever; issue_ready=1 at T+6; a new op issued at T+6 completes at T+23 with a correct result.
  - Flush exactly at the DONE cycle -> wb_valid=0 and muti_finish=0 that cycle.
- Back-to-back: issue_valid held high continuously -> accepts at T and T+18 only; two wb_valid pulses at T+17 and T+35; muti_finish identical to wb_valid.
- rst_n low at T+8 mid-operation -> next cycle busy=0, wb_valid=0, wb_data=0, issue_ready=1; no stale writeback; issue_valid with flush=1 in IDLE -> not accepted, busy stays 0.
